// File: rtl/twid_ram_gen_pkg.sv
// twid_ram_gen_pkg: shared twiddle-RAM FSM states and saturating negate.
package twid_ram_gen_pkg;
  typedef enum logic {INIT, READY} twidState_t;
  localparam int SAT_W = 64;
  // x holds a w-bit two's complement value sign-extended to SAT_W bits.
  function automatic logic [SAT_W-1:0] satNeg(input logic [SAT_W-1:0] x, input int unsigned w);
    logic [SAT_W-1:0] minV;
    minV = {SAT_W{1'b1}} << (w - 1);
    return (x == minV) ? ~minV : -x;
  endfunction
endpackage

// File: rtl/twid_ram_core.sv
// twid_ram_core: reset-free storage array, synchronous write and registered read.
module twid_ram_core
  import twid_ram_gen_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              wEn,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wD,
  input  logic              rEn,
  input  logic [ADDR_W-1:0] rAddr,
  output logic [DATA_W-1:0] rQ
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (wEn) mem[wAddr] <= wD;
    if (rEn) rQ <= mem[rAddr];
  end
endmodule

// File: rtl/twid_ram_gen.sv
// twid_ram_gen: twiddle RAM with zeroing sweep, write-first bypass,
// optional conjugation and a 1- or 2-cycle read pipeline.
module twid_ram_gen
  import twid_ram_gen_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH = 4,
  parameter int RD_LAT = 1,
  localparam int ADDR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              nGrst,
  input  logic              clr,
  input  logic              wEn,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wD,
  input  logic              rEn,
  input  logic [ADDR_W-1:0] rAddr,
  input  logic              conj,
  output logic [DATA_W-1:0] rD,
  output logic              rValid,
  output logic              busy
);
  localparam int H = DATA_W / 2;
  twidState_t state, nextState;
  logic [ADDR_W-1:0] cnt, nextCnt;
  logic wIn, rIn, wAcc, rAcc;
  logic v1, byp1, oob1, cj1;
  logic [DATA_W-1:0] bypD1, rQ, d1, c1;
  logic [H-1:0] ng;
  assign busy = (state == INIT);
  assign wIn = 32'(wAddr) < DEPTH;
  assign rIn = 32'(rAddr) < DEPTH;
  assign wAcc = wEn & ~busy & wIn;
  assign rAcc = rEn & ~busy;
  always_ff @(posedge clk or negedge nGrst)
    if (!nGrst) begin
      state <= INIT;
      cnt <= '0;
    end else begin
      state <= nextState;
      cnt <= nextCnt;
    end
  always_comb begin
    nextState = state;
    nextCnt = cnt;
    if (state == INIT) begin
      nextCnt = clr ? '0 : ADDR_W'(cnt + 1'b1);
      if (!clr && cnt == ADDR_W'(DEPTH - 1)) begin
        nextState = READY;
        nextCnt = '0;
      end
    end else if (clr) begin
      nextState = INIT;
      nextCnt = '0;
    end
  end
  // The sweep owns the write port while busy.
  twid_ram_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) uCore (
    .clk  (clk),
    .wEn  (busy | wAcc),
    .wAddr(busy ? cnt : wAddr),
    .wD   (busy ? '0 : wD),
    .rEn  (rAcc & rIn),
    .rAddr(rAddr),
    .rQ   (rQ)
  );
  always_ff @(posedge clk or negedge nGrst)
    if (!nGrst) begin
      v1 <= 1'b0;
      byp1 <= 1'b0;
      oob1 <= 1'b0;
      cj1 <= 1'b0;
      bypD1 <= '0;
    end else begin
      v1 <= rAcc;
      if (rAcc) begin
        byp1 <= wAcc && (wAddr == rAddr);
        oob1 <= !rIn;
        cj1 <= conj;
        bypD1 <= wD;
      end
    end
  always_comb begin
    d1 = oob1 ? '0 : byp1 ? bypD1 : rQ;
    ng = H'(satNeg(SAT_W'($signed(d1[DATA_W-1:H])), H));
    c1 = cj1 ? {ng, d1[H-1:0]} : d1;
  end
  generate
    if (RD_LAT == 1) begin : gLat1
      logic [DATA_W-1:0] hold;
      always_ff @(posedge clk or negedge nGrst)
        if (!nGrst) hold <= '0;
        else if (v1) hold <= c1;
      assign rD = v1 ? c1 : hold;
      assign rValid = v1;
    end else begin : gLat2
      always_ff @(posedge clk or negedge nGrst)
        if (!nGrst) begin
          rValid <= 1'b0;
          rD <= '0;
        end else begin
          rValid <= v1;
          if (v1) rD <= c1;
        end
    end
  endgenerate
endmodule

// File: tb/tb_twid_ram_gen.sv
// tb_twid_ram_gen: scoreboard bench driving a latency-1 and a latency-2 instance in lockstep.
module tb_twid_ram_gen;
  localparam int DEPTH = 4;
  typedef struct {logic [63:0] d; int due;} item_t;
  logic clk = 0, nGrst = 0, clr = 0, wEn = 0, rEn = 0, conj = 0;
  logic [1:0] wAddr = 0, rAddr = 0;
  logic [63:0] wD = 0;
  logic [63:0] rD1, rD2;
  logic rValid1, rValid2, busy1, busy2;
  item_t sb[2][$];
  logic [63:0] lastD[2];
  logic [63:0] model[DEPTH];
  int cyc = 0, busyLeft = 0, nChecks = 0, nFails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  twid_ram_gen #(.DATA_W(64), .DEPTH(DEPTH), .RD_LAT(1)) dut1 (
    .clk(clk), .nGrst(nGrst), .clr(clr), .wEn(wEn), .wAddr(wAddr), .wD(wD),
    .rEn(rEn), .rAddr(rAddr), .conj(conj), .rD(rD1), .rValid(rValid1), .busy(busy1));
  twid_ram_gen #(.DATA_W(64), .DEPTH(DEPTH), .RD_LAT(2)) dut2 (
    .clk(clk), .nGrst(nGrst), .clr(clr), .wEn(wEn), .wAddr(wAddr), .wD(wD),
    .rEn(rEn), .rAddr(rAddr), .conj(conj), .rD(rD2), .rValid(rValid2), .busy(busy2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] conjM(input logic [63:0] x);
    logic [31:0] im;
    im = x[63:32];
    im = (im == 32'h8000_0000) ? 32'h7fff_ffff : -im;
    return {im, x[31:0]};
  endfunction

  task automatic mon(input int id, input logic v, input logic [63:0] d);
    item_t e;
    if (v) begin
      if (sb[id].size() == 0) check($sformatf("unexpected_rValid%0d", id), 64'(v), 64'd0);
      else begin
        e = sb[id].pop_front();
        check($sformatf("rD%0d", id), d, e.d);
        check($sformatf("latency%0d", id), 64'(cyc), 64'(e.due));
      end
      lastD[id] = d;
    end else begin
      check($sformatf("hold%0d", id), d, lastD[id]);
      if (sb[id].size() != 0 && sb[id][0].due <= cyc) begin
        check($sformatf("missing_rValid%0d", id), 64'(v), 64'd1);
        void'(sb[id].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rValid1, rD1);
    mon(1, rValid2, rD2);
  end

  task automatic drive(input logic c, input logic we, input logic [1:0] wa, input logic [63:0] wd,
                       input logic re, input logic [1:0] ra, input logic cj);
    logic [63:0] e;
    clr = c; wEn = we; wAddr = wa; wD = wd; rEn = re; rAddr = ra; conj = cj;
    check("busy1", 64'(busy1), 64'(busyLeft > 0));
    check("busy2", 64'(busy2), 64'(busyLeft > 0));
    if (busyLeft == 0) begin
      if (re) begin
        e = (we && wa == ra) ? wd : model[ra];
        if (cj) e = conjM(e);
        sb[0].push_back('{e, cyc + 1});
        sb[1].push_back('{e, cyc + 2});
      end
      if (we) model[wa] = wd;
    end
    if (c) begin
      busyLeft = DEPTH;
      model = '{default: 64'd0};
    end else if (busyLeft > 0) busyLeft--;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 2'd0, 64'd0, 0, 2'd0, 0);
  endtask

  task automatic rd(input logic [1:0] a, input logic cj);
    drive(0, 0, 2'd0, 64'd0, 1, a, cj);
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    drive(0, 1, a, d, 0, 2'd0, 0);
  endtask

  task automatic doReset();
    nGrst = 0;
    clr = 0; wEn = 0; rEn = 0; conj = 0;
    sb[0].delete();
    sb[1].delete();
    lastD[0] = '0;
    lastD[1] = '0;
    model = '{default: 64'd0};
    busyLeft = DEPTH;
    #3;
    check("reset_rD1", rD1, 64'd0);
    check("reset_rD2", rD2, 64'd0);
    check("reset_rValid1", 64'(rValid1), 64'd0);
    check("reset_rValid2", 64'(rValid2), 64'd0);
    check("reset_busy", 64'(busy1), 64'd1);
    @(posedge clk);
    #1;
    nGrst = 1;
  endtask

  initial begin
    doReset();
    idle(5);
    for (int a = 0; a < DEPTH; a++) rd(2'(a), 0);
    wr(2, 64'h0001_0002_0003_0004);
    rd(2, 0);
    idle(1);
    rd(2, 0);
    drive(0, 1, 2'd1, 64'hDEAD_BEEF_0000_0001, 1, 2'd1, 0);
    wr(0, 64'h8000_0000_1234_5678);
    wr(3, 64'h0000_0005_8765_4321);
    rd(0, 1);
    rd(3, 1);
    rd(3, 0);
    rd(1, 1);
    idle(3);
    rd(2, 0);
    rd(1, 0);
    drive(1, 0, 2'd0, 64'd0, 0, 2'd0, 0);
    rd(1, 0);
    idle(3);
    for (int a = 0; a < DEPTH; a++) rd(2'(a), 0);
    idle(2);
    repeat (80) drive(($urandom_range(15) == 0), 1'($urandom), 2'($urandom), {$urandom, $urandom},
                      1'($urandom), 2'($urandom), 1'($urandom));
    idle(DEPTH + 3);
    wr(2, 64'h1111_2222_3333_4444);
    rd(2, 0);
    doReset();
    idle(4);
    rd(2, 0);
    for (int a = 0; a < DEPTH; a++) wr(2'(a), 64'hA5A5_0000_0000_0000 + 64'(a));
    drive(1, 0, 2'd0, 64'd0, 0, 2'd0, 0);
    idle(2);
    doReset();
    idle(4);
    for (int a = 0; a < DEPTH; a++) rd(2'(a), 1);
    idle(4);
    check("drain1", 64'(sb[0].size()), 64'd0);
    check("drain2", 64'(sb[1].size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/twid_ram_gen.md
TWID_RAM_GEN -- requirements
Module: twid_ram_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 64, the stored word width; even, 8..128; word = {imag[DATA_W/2-1:0], real[DATA_W/2-1:0]}, two's complement.
REQ-002 SHALL have parameter DEPTH, default 4, the number of words; 2..1024.
REQ-003 SHALL have parameter RD_LAT, default 1, the read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have local parameter ADDR_W = max(1, clog2(DEPTH)).
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port nGrst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port clr  input  1  single-cycle request to re-initialise the memory.
REQ-008 SHALL have port wEn  input  1  write strobe.
REQ-009 SHALL have port wAddr  input  ADDR_W  write address.
REQ-010 SHALL have port wD  input  DATA_W  write data.
REQ-011 SHALL have port rEn  input  1  read request.
REQ-012 SHALL have port rAddr  input  ADDR_W  read address.
REQ-013 SHALL have port conj  input  1  when high, the read result is conjugated; sampled with rEn.
REQ-014 SHALL have port rD  output  DATA_W  read data.
REQ-015 SHALL have port rValid  output  1  rD is valid this cycle.
REQ-016 SHALL have port busy  output  1  the initialisation sweep is in progress.

Function
REQ-017 SHALL implement a two-state FSM: INIT and READY.
- INIT: a sweep counter writes zero to address 0..DEPTH-1, one address per cycle.
- INIT -> READY: after address DEPTH-1 has been written.
- READY -> INIT: when clr is high; the counter restarts at 0.
REQ-018 SHALL hold busy high exactly while the FSM is in INIT, i.e. for DEPTH cycles per sweep.
REQ-019 SHALL ignore wEn and rEn while busy is high; no rValid is generated for rEn issued in INIT.
REQ-020 SHALL restart the sweep from address 0 when clr is asserted during INIT.
REQ-021 In READY, SHALL write wD to wAddr on each cycle with wEn high.
REQ-022 SHALL ignore any wAddr or rAddr >= DEPTH: a write is dropped; a read returns zero with rValid still asserted.
REQ-023 A read accepted in cycle N SHALL present rD and rValid=1 in cycle N+RD_LAT; rValid SHALL be 0 in all other cycles.
REQ-024 SHALL accept back-to-back reads every cycle (full throughput, no stalls).
REQ-025 When wEn and rEn are high in the same cycle at the same address, the read SHALL return the new wD (write-first bypass).
REQ-026 A read in cycle N+1 of an address written in cycle N SHALL return the new data.
REQ-027 With conj=1, rD SHALL be {sat(-imag), real}.
- sat maps the most-negative value to the most-positive value (-2^(DATA_W/2-1) -> 2^(DATA_W/2-1)-1).
- real is never altered.
REQ-028 SHALL hold rD at its last value while rValid is low.
REQ-029 A clr arriving while reads are in flight SHALL NOT cancel them; reads already accepted complete with pre-clear data.

Reset
REQ-030 nGrst low SHALL asynchronously force: FSM=INIT, sweep counter=0, busy=1, rValid=0, rD=0, and all read-pipeline valid bits=0.
REQ-031 Memory contents are not reset directly; they are zeroed by the INIT sweep after nGrst rises.
REQ-032 nGrst assertion mid-sweep or mid-read SHALL abort the operation; no rValid SHALL appear afterwards for reads accepted before reset.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (INIT, READY) and the sat-negate function, for reuse by other twiddle blocks.
REQ-034 The storage array SHALL be a single sub-module twid_ram_core with a plain synchronous write and registered read.
- twid_ram_core has no reset.
- twid_ram_core is inferable as micro RAM.
- FSM, bypass, conjugation and latency pipeline live in twid_ram_gen.

Verification
REQ-035 Reset release, DATA_W=64, DEPTH=4 -> busy=1 for exactly 4 cycles; reads of all addresses after busy falls return 0.
REQ-036 Write 0x0001_0002_0003_0004 to addr 2, then rEn addr 2 with conj=0, RD_LAT=1 -> rD=0x0001_0002_0003_0004 and rValid=1 exactly one cycle after rEn.
REQ-037 Same-cycle wEn/rEn at addr 1, wD=0xDEAD_BEEF_0000_0001, RD_LAT=2 -> rD=0xDEAD_BEEF_0000_0001 two cycles later.
REQ-038 Conjugation case: stored imag=0x8000_0000, real=0x1234_5678, conj=1 -> rD=0x7FFF_FFFF_1234_5678.
- Companion case: stored imag=0x0000_0005 -> rD imag=0xFFFF_FFFB.
REQ-039 Clear with reads in flight: clr pulsed while 2 reads are in flight.
- Both reads return pre-clear data.
- busy=1 for 4 cycles; a rEn during busy yields no rValid.
- Data read afterwards = 0.
REQ-040 Reset mid-operation: nGrst pulsed low mid-sweep and during a pending read -> rValid never asserts for that read, and the sweep restarts at address 0.
